// File: rtl/instr_mem_arbiter_if.sv
// Bus between the fetch/debug requesters, the instruction memory and the arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface instr_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  f_req_valid;
  logic [ADDR_WIDTH-1:0] f_req_addr;
  logic                  f_req_ready;
  logic                  f_rsp_valid;
  logic [31:0]           f_rsp_instr;
  logic                  f_rsp_err;
  logic                  f_rsp_ready;

  logic                  d_req_valid;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic                  d_req_ready;
  logic                  d_rsp_valid;
  logic [31:0]           d_rsp_instr;
  logic                  d_rsp_err;
  logic                  d_rsp_ready;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_instr;

  modport slave (
    input  f_req_valid, f_req_addr, f_rsp_ready,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    input  mem_instr,
    output f_req_ready, f_rsp_valid, f_rsp_instr, f_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_instr, d_rsp_err,
    output mem_addr
  );

  modport master (
    output f_req_valid, f_req_addr, f_rsp_ready,
    output d_req_valid, d_req_addr, d_rsp_ready,
    output mem_instr,
    input  f_req_ready, f_rsp_valid, f_rsp_instr, f_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_instr, d_rsp_err,
    input  mem_addr
  );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Two-port (fetch/debug) arbiter in front of a combinational-read instruction memory.
// Define INSTR_MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fetch priority.
module instr_mem_arbiter #(
  parameter int NUM_INSTR  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  instr_mem_arbiter_if.slave bus
);
  typedef enum logic {LAST_F, LAST_D} arb_state_e;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(NUM_INSTR * 4 - 4);

  arb_state_e  state_q, state_d;
  logic        f_rsp_valid_q, f_rsp_valid_d;
  logic [31:0] f_rsp_instr_q, f_rsp_instr_d;
  logic        f_rsp_err_q, f_rsp_err_d;
  logic        d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0] d_rsp_instr_q, d_rsp_instr_d;
  logic        d_rsp_err_q, d_rsp_err_d;

  logic f_err, d_err, f_elig, d_elig, f_wins_tie, grant_f, grant_d;

  always_comb begin
    f_err  = (bus.f_req_addr[1:0] != 2'b00) || (bus.f_req_addr > MAX_ADDR);
    d_err  = (bus.d_req_addr[1:0] != 2'b00) || (bus.d_req_addr > MAX_ADDR);
    // rst_n gates eligibility so nothing transfers in a reset cycle
    f_elig = rst_n && bus.f_req_valid && (!f_rsp_valid_q || bus.f_rsp_ready);
    d_elig = rst_n && bus.d_req_valid && (!d_rsp_valid_q || bus.d_rsp_ready);
`ifdef INSTR_MEM_ARBITER_RR_EN
    f_wins_tie = (state_q == LAST_D);
`else
    f_wins_tie = 1'b1;
`endif
    grant_f = f_elig && (!d_elig || f_wins_tie);
    grant_d = d_elig && !grant_f;
  end

  assign bus.f_req_ready = grant_f;
  assign bus.d_req_ready = grant_d;
  assign bus.mem_addr    = (grant_f && !f_err) ? bus.f_req_addr :
                           (grant_d && !d_err) ? bus.d_req_addr : '0;

  // Masking with rst_n keeps a response pending at reset from being handed over
  assign bus.f_rsp_valid = f_rsp_valid_q && rst_n;
  assign bus.f_rsp_instr = f_rsp_instr_q;
  assign bus.f_rsp_err   = f_rsp_err_q;
  assign bus.d_rsp_valid = d_rsp_valid_q && rst_n;
  assign bus.d_rsp_instr = d_rsp_instr_q;
  assign bus.d_rsp_err   = d_rsp_err_q;

  always_comb begin
    state_d       = state_q;
    f_rsp_valid_d = f_rsp_valid_q && !bus.f_rsp_ready;
    f_rsp_instr_d = f_rsp_instr_q;
    f_rsp_err_d   = f_rsp_err_q;
    d_rsp_valid_d = d_rsp_valid_q && !bus.d_rsp_ready;
    d_rsp_instr_d = d_rsp_instr_q;
    d_rsp_err_d   = d_rsp_err_q;
    if (grant_f) begin
      state_d       = LAST_F;
      f_rsp_valid_d = 1'b1;
      f_rsp_instr_d = f_err ? '0 : bus.mem_instr;
      f_rsp_err_d   = f_err;
    end
    if (grant_d) begin
      state_d       = LAST_D;
      d_rsp_valid_d = 1'b1;
      d_rsp_instr_d = d_err ? '0 : bus.mem_instr;
      d_rsp_err_d   = d_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= LAST_D;
      f_rsp_valid_q <= 1'b0;
      f_rsp_instr_q <= '0;
      f_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_instr_q <= '0;
      d_rsp_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      f_rsp_valid_q <= f_rsp_valid_d;
      f_rsp_instr_q <= f_rsp_instr_d;
      f_rsp_err_q   <= f_rsp_err_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_instr_q <= d_rsp_instr_d;
      d_rsp_err_q   <= d_rsp_err_d;
    end
  end
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: directed vector table, random traffic against a
// transaction-level model, and a tie-breaking grant pattern sequence.
module tb_instr_mem_arbiter;
  localparam int NI = 32;
  localparam int AW = 32;
`ifdef INSTR_MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  instr_mem_arbiter #(.NUM_INSTR(NI), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [NI];
  always_comb begin
    if ((bus.mem_addr >> 2) < NI) bus.mem_instr = mem[bus.mem_addr >> 2];
    else                          bus.mem_instr = 32'hBAD0_BAD0;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit fv, input logic [31:0] fa, input bit frr,
                       input bit dv, input logic [31:0] da, input bit drr);
    rst_n           = r;
    bus.f_req_valid = fv;
    bus.f_req_addr  = fa;
    bus.f_rsp_ready = frr;
    bus.d_req_valid = dv;
    bus.d_req_addr  = da;
    bus.d_rsp_ready = drr;
  endtask

  typedef struct {
    bit r, fv, frr, dv, drr;
    logic [31:0] fa, da;
    bit efr, edr;
    logic [31:0] ema;
    bit efv; logic [31:0] efi; bit efe;
    bit edv; logic [31:0] edi; bit ede;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit fv, logic [31:0] fa, bit frr,
                              bit dv, logic [31:0] da, bit drr,
                              bit efr, bit edr, logic [31:0] ema,
                              bit efv, logic [31:0] efi, bit efe,
                              bit edv, logic [31:0] edi, bit ede);
    vec_t v;
    v.r = r; v.fv = fv; v.fa = fa; v.frr = frr; v.dv = dv; v.da = da; v.drr = drr;
    v.efr = efr; v.edr = edr; v.ema = ema;
    v.efv = efv; v.efi = efi; v.efe = efe; v.edv = edv; v.edi = edi; v.ede = ede;
    return v;
  endfunction

  // Transaction-level model: one pending response slot per port, last winner remembered
  bit          pv [2];
  logic [31:0] pi [2];
  bit          pe [2];
  int          last_port;

  task automatic model_cycle(input bit r, input bit fv, input logic [31:0] fa, input bit frr,
                             input bit dv, input logic [31:0] da, input bit drr,
                             output bit d_granted);
    bit v[2], rr[2], elig[2], err[2];
    logic [31:0] a[2];
    int win;
    @(negedge clk);
    drive(r, fv, fa, frr, dv, da, drr);
    #1;
    v[0] = fv; v[1] = dv; rr[0] = frr; rr[1] = drr; a[0] = fa; a[1] = da;
    for (int p = 0; p < 2; p++) begin
      elig[p] = r && v[p] && (!pv[p] || rr[p]);
      err[p]  = (a[p] % 4 != 0) || (a[p] > NI * 4 - 4);
    end
    if (elig[0] && elig[1]) win = (RR && last_port == 0) ? 1 : 0;
    else if (elig[0])       win = 0;
    else if (elig[1])       win = 1;
    else                    win = -1;
    chk("f_req_ready", 32'(bus.f_req_ready), 32'(win == 0));
    chk("d_req_ready", 32'(bus.d_req_ready), 32'(win == 1));
    chk("mem_addr", bus.mem_addr, (win >= 0 && !err[win]) ? a[win] : 32'h0);
    chk("f_rsp_valid", 32'(bus.f_rsp_valid), 32'(r && pv[0]));
    chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(r && pv[1]));
    if (r && pv[0]) begin
      chk("f_rsp_instr", bus.f_rsp_instr, pi[0]);
      chk("f_rsp_err", 32'(bus.f_rsp_err), 32'(pe[0]));
    end
    if (r && pv[1]) begin
      chk("d_rsp_instr", bus.d_rsp_instr, pi[1]);
      chk("d_rsp_err", 32'(bus.d_rsp_err), 32'(pe[1]));
    end
    d_granted = bus.d_req_ready;
    @(posedge clk);
    if (!r) begin
      pv[0] = 1'b0; pv[1] = 1'b0; last_port = 1;
    end else begin
      for (int p = 0; p < 2; p++) if (pv[p] && rr[p]) pv[p] = 1'b0;
      if (win >= 0) begin
        pv[win] = 1'b1;
        pe[win] = err[win];
        pi[win] = err[win] ? 32'h0 : mem[a[win] / 4];
        last_port = win;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 7);
    if (sel == 0) return ($urandom_range(0, NI - 1) * 4) | $urandom_range(1, 3);
    if (sel == 1) return (NI * 4) + $urandom_range(0, 255);
    return $urandom_range(0, NI - 1) * 4;
  endfunction

  initial begin
    bit dg;
    logic [5:0] gseq;
    for (int i = 0; i < NI; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    mem[2] = 32'h0050_0093;

    //      r fv fa        frr dv da        drr efr edr ema       efv efi           efe edv edi           ede
    tbl.push_back(mk(0, 1, 32'h08, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h08, 1, 0, 32'h00, 1, 1, 0, 32'h08, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0, 32'h00, 1, 32'h00500093, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 32'h00, 1, 1, 32'h06, 1, 0, 1, 32'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 32'h00, 1, 1, 32'h80, 1, 0, 1, 32'h00, 0, 32'h0,        0, 1, 32'h0,        1));
    tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 32'h0,        0, 1, 32'h0,        1));
    tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 32'h00, 1, 1, 32'h7C, 1, 0, 1, 32'h7C, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 32'h0,        0, 1, 32'hA5A5001F, 0));
    tbl.push_back(mk(1, 1, 32'h04, 1, 0, 32'h00, 1, 1, 0, 32'h04, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h08, 0, 1, 32'h40, 1, 0, 1, 32'h40, 1, 32'hA5A50001, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h08, 0, 1, 32'h44, 1, 0, 1, 32'h44, 1, 32'hA5A50001, 0, 1, 32'hA5A50010, 0));
    tbl.push_back(mk(1, 1, 32'h08, 0, 1, 32'h48, 1, 0, 1, 32'h48, 1, 32'hA5A50001, 0, 1, 32'hA5A50011, 0));
    tbl.push_back(mk(1, 1, 32'h08, 1, 0, 32'h00, 1, 1, 0, 32'h08, 1, 32'hA5A50001, 0, 1, 32'hA5A50012, 0));
    tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0, 32'h00, 1, 32'h00500093, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h00, 1, 0, 32'h00, 1, 1, 0, 32'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 1, 32'h00, 1, 1, 32'h50, 1, 0, 0, 32'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 32'h0C, 1, 1, 32'h50, 1, 1, 0, 32'h0C, 0, 32'h0,        0, 0, 32'h0,        0));
    if (RR) begin
      tbl.push_back(mk(1, 1, 32'h10, 1, 1, 32'h54, 1, 0, 1, 32'h54, 1, 32'hA5A50003, 0, 0, 32'h0,        0));
      tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 32'h0,        0, 1, 32'hA5A50015, 0));
    end else begin
      tbl.push_back(mk(1, 1, 32'h10, 1, 1, 32'h54, 1, 1, 0, 32'h10, 1, 32'hA5A50003, 0, 0, 32'h0,        0));
      tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, 1, 0, 0, 32'h00, 1, 32'hA5A50004, 0, 0, 32'h0,        0));
    end

    drive(0, 0, '0, 0, 0, '0, 0);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].fv, tbl[i].fa, tbl[i].frr, tbl[i].dv, tbl[i].da, tbl[i].drr);
      #1;
      chk($sformatf("v%0d f_req_ready", i), 32'(bus.f_req_ready), 32'(tbl[i].efr));
      chk($sformatf("v%0d d_req_ready", i), 32'(bus.d_req_ready), 32'(tbl[i].edr));
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].ema);
      chk($sformatf("v%0d f_rsp_valid", i), 32'(bus.f_rsp_valid), 32'(tbl[i].efv));
      chk($sformatf("v%0d d_rsp_valid", i), 32'(bus.d_rsp_valid), 32'(tbl[i].edv));
      if (tbl[i].efv) begin
        chk($sformatf("v%0d f_rsp_instr", i), bus.f_rsp_instr, tbl[i].efi);
        chk($sformatf("v%0d f_rsp_err", i), 32'(bus.f_rsp_err), 32'(tbl[i].efe));
      end
      if (tbl[i].edv) begin
        chk($sformatf("v%0d d_rsp_instr", i), bus.d_rsp_instr, tbl[i].edi);
        chk($sformatf("v%0d d_rsp_err", i), 32'(bus.d_rsp_err), 32'(tbl[i].ede));
      end
    end

    pv[0] = 1'b0; pv[1] = 1'b0; last_port = 1;
    model_cycle(0, 0, '0, 0, 0, '0, 0, dg);
    for (int n = 0; n < 3000; n++) begin
      model_cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 3) != 0), dg);
    end

    // Continuous contention after reset: grant pattern F,D,F,D... or all F
    model_cycle(0, 0, '0, 1, 0, '0, 1, dg);
    for (int k = 0; k < 6; k++) begin
      model_cycle(1, 1, 32'(k * 4), 1, 1, 32'(32'h40 + k * 4), 1, dg);
      gseq[k] = dg;
    end
    chk("grant_pattern", 32'(gseq), RR ? 32'b101010 : 32'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 Parameter: NUM_INSTR, default 32, instruction-memory depth in 32-bit words; the byte-address space is 0 .. NUM_INSTR*4-1.
REQ-002 Parameter: ADDR_WIDTH, default 32, width of every address port.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset.
REQ-005 Ports, fetch requester (f_): f_req_valid in 1, f_req_addr in ADDR_WIDTH, f_req_ready out 1, f_rsp_valid out 1, f_rsp_instr out 32, f_rsp_err out 1, f_rsp_ready in 1.
REQ-006 Ports, debug requester (d_): d_req_valid, d_req_addr, d_req_ready, d_rsp_valid, d_rsp_instr, d_rsp_err, d_rsp_ready; widths and directions are identical to the f_ ports.
REQ-007 Ports, memory side: mem_addr out ADDR_WIDTH, byte address to the combinational-read instruction memory; mem_instr in 32, big-endian word at mem_addr..mem_addr+3.

Function
REQ-008 A request transfers when req_valid and req_ready are both 1 in the same cycle; at most one request (fetch or debug) SHALL transfer per cycle.
REQ-009 Port p req_ready SHALL be 1 only when p is granted this cycle and p's response slot is free (p_rsp_valid=0, or p_rsp_ready=1 this cycle).
REQ-010 In a granted cycle, mem_addr SHALL equal the granted req_addr combinationally; otherwise mem_addr = 0.
REQ-011 Latency: mem_instr is captured on the transfer edge; p_rsp_valid SHALL rise exactly one cycle after the transfer.
REQ-012 p_rsp_valid, p_rsp_instr and p_rsp_err SHALL hold stable until p_rsp_valid and p_rsp_ready are both 1; a new response may load on that same edge (back-to-back, 1 request per cycle per port).
REQ-013 Arbitration FSM, states LAST_F and LAST_D, recording the last port granted. If only one eligible port (req_valid=1 and slot free) exists, it wins. If both are eligible, in LAST_F debug wins; in LAST_D fetch wins.
REQ-014 FSM transitions occur only on a transfer: to LAST_F on a fetch transfer, to LAST_D on a debug transfer; otherwise the state holds.
REQ-015 An ineligible port SHALL NOT consume the grant; the other valid port is granted in the same cycle.
REQ-016 Error: a request with addr[1:0] != 0 or addr > NUM_INSTR*4-4 SHALL still transfer, SHALL produce rsp_err=1 and rsp_instr=0, and SHALL drive mem_addr=0.
REQ-017 Requests with req_valid=0 are ignored regardless of the req_addr value.

Reset
REQ-018 While rst_n=0 at an edge: FSM -> LAST_D (fetch wins the first tie), f/d_rsp_valid=0, f/d_rsp_instr=0, f/d_rsp_err=0.
REQ-019 During the reset cycle req_ready SHALL be 0 for both ports; a response pending when reset is asserted is discarded, not delivered.

Configuration
REQ-020 Macro INSTR_MEM_ARBITER_RR_EN. Defined: round-robin per REQ-013. Undefined: fixed priority, fetch always wins ties; FSM state is retained but ignored for arbitration.

Verification
REQ-021 Reset, then f_req_valid=1 at f_req_addr=0x8 with mem word 0x00500093 -> f_req_ready=1 in the same cycle, mem_addr=0x8, and next cycle f_rsp_valid=1, f_rsp_instr=0x00500093, f_rsp_err=0.
REQ-022 Both ports valid continuously with rsp_ready=1, fetch addresses 0x0,0x4,... and debug 0x40,0x44,... -> grants alternate F,D,F,D starting with F under RR_EN; all grants go to F without RR_EN.
REQ-023 f_rsp_ready=0 for 3 cycles while f_rsp_valid=1 -> the response holds stable, f_req_ready=0, and a valid debug request is granted every cycle.
REQ-024 d_req_addr=0x6 and, separately, d_req_addr=0x80 with NUM_INSTR=32 -> d_rsp_valid=1, d_rsp_err=1, d_rsp_instr=0, mem_addr=0 in the request cycle.
REQ-025 rst_n=0 in the cycle after a fetch transfer -> f_rsp_valid stays 0 and the FSM is LAST_D; a simultaneous F/D request after reset is granted to F.
